// File: rtl/rsa_operand_fetch_ctrl_if.sv
// Operand-fetch bus: SRAM read port plus the outgoing operand word stream.
//
//   sram_en    fetch -> SRAM   read enable / address capture strobe
//   sram_addr  fetch -> SRAM   read address
//   sram_data  SRAM  -> fetch  read data, valid the cycle after sram_en
//   out_valid  fetch -> core   stream word valid
//   out_ready  core  -> fetch  core accepts when out_valid & out_ready
//   out_data   fetch -> core   stream word
//   out_sel    fetch -> core   operand tag: 0 = N, 1 = key, 2 = message
//   out_last   fetch -> core   last word of the current operand
//
// Stream handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data/out_sel/out_last
// stay stable until the transfer happens; out_ready may change freely and has
// no effect while out_valid is low.
interface rsa_operand_fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              sram_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_sel;
  logic              out_last;

  modport master (
    output sram_en, sram_addr, out_valid, out_data, out_sel, out_last,
    input  sram_data, out_ready
  );

  modport slave (
    input  sram_en, sram_addr, out_valid, out_data, out_sel, out_last,
    output sram_data, out_ready
  );
endinterface

// File: rtl/rsa_operand_fetch_ctrl.sv
// RSA operand fetch sequencer. Streams modulus N, then the key, then the
// message out of the operand SRAM onto a valid/ready word stream at up to one
// word per cycle. The SRAM's registered read output doubles as the stream
// register: a new address is only issued when the word on out_data is being
// accepted (or none is held), so backpressure simply freezes the SRAM output.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      one-cycle request to begin a sequence (ignored unless idle)
//   msg_only   sampled with start: fetch the message operand only
//   bus        master side of rsa_operand_fetch_ctrl_if (SRAM + stream)
//   busy       sequence in progress (first issue through final accept)
//   done       one-cycle pulse after the final word is accepted
//   state_dbg  current FSM state encoding
module rsa_operand_fetch_ctrl #(
  parameter int OP_WORDS = 64,
  parameter int MSG_BASE = 0,
  parameter int KEY_BASE = 64,
  parameter int MOD_BASE = 128,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic msg_only,
  rsa_operand_fetch_ctrl_if.master bus,
  output logic busy,
  output logic done,
  output logic [2:0] state_dbg
);

  localparam int WORD_W = $clog2(OP_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(OP_WORDS - 1);
  localparam logic [ADDR_W-1:0] MOD_B = ADDR_W'(MOD_BASE);
  localparam logic [ADDR_W-1:0] KEY_B = ADDR_W'(KEY_BASE);
  localparam logic [ADDR_W-1:0] MSG_B = ADDR_W'(MSG_BASE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_N = 3'd1,
    S_FETCH_K = 3'd2,
    S_FETCH_M = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Issue pointer: operand index (0 = N, 1 = key, 2 = message, 3 = all
  // issued) and word index within that operand. It runs ahead of the
  // accepted word by at most one, independently of the FSM, so issue
  // crosses operand boundaries without a bubble.
  logic [1:0]        iss_op;
  logic [WORD_W-1:0] iss_word;
  // Tags of the word currently held on the SRAM output.
  logic [1:0]        out_op;
  logic              out_last_q;
  logic              out_valid_q;

  logic active, issue, accept, last_accept;
  logic [ADDR_W-1:0] op_base;

  assign active      = (state == S_FETCH_N) || (state == S_FETCH_K) ||
                       (state == S_FETCH_M);
  assign issue       = active && (iss_op != 2'd3) &&
                       (!out_valid_q || bus.out_ready);
  assign accept      = out_valid_q && bus.out_ready;
  assign last_accept = accept && out_last_q;

  always_comb begin
    case (iss_op)
      2'd0:    op_base = MOD_B;
      2'd1:    op_base = KEY_B;
      default: op_base = MSG_B;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; operand phases advance on acceptance of their last word.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = msg_only ? S_FETCH_M : S_FETCH_N;
      S_FETCH_N: if (last_accept) state_nxt = S_FETCH_K;
      S_FETCH_K: if (last_accept) state_nxt = S_FETCH_M;
      S_FETCH_M: if (last_accept) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy          = active;
    done          = (state == S_DONE);
    bus.sram_en   = issue;
    bus.sram_addr = active ? (op_base + ADDR_W'(iss_word)) : '0;
  end

  // Issue pointer and held-word tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_op      <= 2'd0;
      iss_word    <= '0;
      out_op      <= 2'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        iss_op   <= msg_only ? 2'd2 : 2'd0;
        iss_word <= '0;
      end else if (issue) begin
        out_op     <= iss_op;
        out_last_q <= (iss_word == LAST_WORD);
        if (iss_word == LAST_WORD) begin
          iss_word <= '0;
          iss_op   <= iss_op + 2'd1;
        end else begin
          iss_word <= iss_word + WORD_W'(1);
        end
      end
      // Data arrives the cycle after issue; it stays until accepted.
      out_valid_q <= issue || (out_valid_q && !bus.out_ready);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = bus.sram_data;
  assign bus.out_sel   = out_op;
  assign bus.out_last  = out_valid_q && out_last_q;
  assign state_dbg     = state;

endmodule

// File: doc/rsa_operand_fetch_ctrl.md
Name: rsa_operand_fetch_ctrl

Overview:
Sequencer that streams the RSA operands from the 256x32 operand SRAM into the modular-exponentiation core. The SRAM map is fixed: message words 0-63, key (D or E) 64-127, modulus N 128-191. The block reads them in the order N, key, message and presents them on a valid/ready word stream at up to one word per cycle. It absorbs the SRAM's 1-cycle registered-address read latency and core backpressure without skid storage.

Parameters:
OP_WORDS, 64, 32-bit words per operand (2048-bit operands).
MSG_BASE, 0, SRAM base address of the message block.
KEY_BASE, 64, SRAM base address of the key.
MOD_BASE, 128, SRAM base address of modulus N.
ADDR_W, 8, SRAM address width.
DATA_W, 32, SRAM and stream word width.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin a fetch sequence; ignored while busy.
msg_only  input  1  sampled with start: 1 = skip N and key and fetch the message only (core already holds N/key).
sram_en  output  1  SRAM read enable (address capture strobe).
sram_addr  output  ADDR_W  SRAM read address.
sram_data  input  DATA_W  SRAM read data, valid the cycle after en/addr.
out_valid  output  1  stream word valid.
out_ready  input  1  core accepts word when out_valid & out_ready.
out_data  output  DATA_W  stream word; driven directly from sram_data.
out_sel  output  2  operand tag: 0 = N, 1 = key, 2 = message, 3 unused.
out_last  output  1  high with word index OP_WORDS-1 of each operand.
busy  output  1  sequence in progress.
done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset values: sram_en=0, sram_addr=0, out_valid=0, out_sel=0, out_last=0, busy=0, done=0. FSM returns to IDLE and word/issue counters clear. Any in-flight SRAM read is discarded. Reset takes priority over every other input in the same cycle.
- FSM states and transitions:
  - IDLE: on start go to FETCH_N, or to FETCH_M when msg_only=1.
  - FETCH_N -> FETCH_K -> FETCH_M: each advances when its last word (out_last) is accepted.
  - FETCH_M -> DONE.
  - DONE -> IDLE after one cycle, with done=1 in DONE.
- Timing: start sampled at edge T. busy=1 from cycle T+1 until the final accept cycle inclusive. sram_en=1 with the first address in cycle T+1. out_valid first high in T+2.
- Issue rule: sram_en = active & words_remaining_to_issue & (!out_valid | out_ready). The next address issues in the same cycle the current word is accepted, giving 1 word/cycle with out_ready held high.
- Stall: when out_valid=1 and out_ready=0, sram_en stays 0. SRAM read_addr is therefore unchanged, so out_data holds stable. No word is dropped or duplicated.
- Address sequence: base+0 … base+OP_WORDS-1 per operand, with a jump at operand boundaries (128→191, then 64→127, then 0→63). Issue across a boundary is back-to-back with no bubble.
- out_valid clears the cycle after the final accept if nothing further is issued. out_sel/out_last describe the word currently on out_data.
- start while busy or in DONE: ignored, no state change.
- out_ready while out_valid=0: no effect.
- rst mid-sequence: the next cycle is in IDLE with all outputs at reset values. A later start restarts from the beginning of the sequence.

Test Plan:
1. rst then start, msg_only=0, out_ready=1 -> sram_addr 128..191, 64..127, 0..63 on consecutive cycles T+1..T+192. 192 accepts at T+2..T+193 with out_sel 0/1/2 in 64-word runs and out_last at accepts 64, 128, 192. done=1 only at T+194, busy=0 at T+194.
2. start with msg_only=1 -> addresses 0..63 only, out_sel=2 throughout, done at T+66. Stream words equal SRAM words 0..63.
3. Full run with out_ready=0 for 3 cycles while word 5 (addr 133) is on out_data -> sram_en=0 and out_data constant during the stall. Words resume at addr 134, 192 words total with no duplicates; done delayed exactly 3 cycles (T+197).
4. Random out_ready (~50%) over a full run -> accepted sequence equals SRAM contents in order N, key, message. Accept count=192, exactly one done pulse.
5. Second start pulse at T+50 while busy -> ignored: same address stream and a single done.
6. rst asserted on the accept cycle of word 100 -> next cycle out_valid=0, sram_en=0, busy=0, no done. A subsequent start begins again at addr 128 and completes normally.
